uart_tx_engine: RTL and testbench
=================================

Name: uart_tx_engine

Overview:
- Parametrised UART transmit engine: frame control FSM, serializer, parity generator and output mux in one block.
- Generalises the fixed-8-bit TX FSM with:
  - configurable data width
  - selectable odd/even parity
  - one or two stop bits
  - baud-tick pacing
  - back-to-back frames with no idle gap
- Sits between the TX data source (valid-driven) and the UART line driver; one baud_tick enable per bit period comes from the baud generator.

Parameters:
- DATA_WIDTH, 8, payload bits per frame; legal range 5..16.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-low reset (clk domain)
- baud_tick  input  1  one-cycle enable marking a bit-period boundary
- p_data  input  DATA_WIDTH  parallel payload, LSB transmitted first
- data_valid  input  1  payload present; sampled only at acceptance points
- par_en  input  1  1 = append parity bit
- par_typ  input  1  0 = even, 1 = odd
- stop2  input  1  1 = two stop bits
- tx_out  output  1  serial line, idle high, registered
- busy  output  1  frame in progress, registered
- frame_done  output  1  one-cycle pulse at the end of the last stop bit

Behaviour:
- Reset: sampled on the rising clk edge while rst=0.
  - State IDLE, tx_out=1, busy=0, frame_done=0.
  - Bit counter and data/config registers cleared.
- Reset mid-frame: frame abandoned, tx_out=1 on the next edge, no frame_done.
- All state changes happen on edges where baud_tick=1, except reset. Each non-IDLE state lasts exactly one bit period.
- States:
  - IDLE: tx_out=1, busy=0. On an edge with data_valid=1 and baud_tick=1:
    - latch p_data, par_en, par_typ, stop2
    - compute parity = ^p_data XOR par_typ
    - go to START
  - START: tx_out=0, busy=1. On tick go to DATA, bit counter=0.
  - DATA: tx_out=shift_reg[0]. On tick shift right and increment the counter. On the tick with counter=DATA_WIDTH-1, go to PARITY if par_en latched, else STOP1.
  - PARITY: tx_out=latched parity. On tick go to STOP1.
  - STOP1: tx_out=1. On tick go to STOP2 if stop2 latched; otherwise this is the final stop bit.
  - STOP2: tx_out=1. On tick this is the final stop bit.
- Final stop tick:
  - frame_done=1 for that one cycle (registered, visible the cycle after the tick edge).
  - If data_valid=1 on that same edge: latch the new frame and go directly to START, busy stays 1, no idle bit.
  - Otherwise go to IDLE, busy=0.
- data_valid is ignored in every state/cycle except the acceptance points: IDLE on a tick, and the final stop tick.
  - The source holds data_valid until it sees busy rise, or frame_done when back-to-back.
  - Input config changes mid-frame have no effect; only the latched copies are used.
- Outputs are registered. tx_out changes one cycle after the tick edge that changes state. Bit period = tick period.
- Frame length in ticks = 1 + DATA_WIDTH + par_en + 1 + stop2.
- Bit counter width: $clog2(DATA_WIDTH); no wrap beyond DATA_WIDTH-1.
- baud_tick high for consecutive cycles is legal: each high cycle advances one bit.

Decomposition:
- Package uart_tx_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP1, STOP2)
  - mux-select constants (MUX_START=2'b00, MUX_DATA=2'b01, MUX_PAR=2'b10, MUX_STOP=2'b11)
  - PAR_EVEN/PAR_ODD constants
- One sub-module: uart_tx_serializer. It handles load, shift on enable, bit counter and ser_done. FSM and mux stay in uart_tx_engine.

Test Plan:
- Reset hold: rst=0 for 3 cycles with data_valid=1 and ticks running -> tx_out=1, busy=0, frame_done=0 throughout; release -> still IDLE until data_valid coincides with a tick.
- p_data=0xA5, par_en=0, stop2=0, tick every 4 clk -> tx_out per bit = 0,1,0,1,0,0,1,0,1,1 (10 bits, 40 clk); busy high 40 clk; single frame_done pulse.
- p_data=0x07, par_en=1:
  - par_typ=0 -> parity bit 1
  - par_typ=1 -> parity bit 0
  - stop2=1 -> two high stop bits; frame = 12 ticks.
- Back-to-back: data_valid held with 0x55 then 0xAA -> the second start bit immediately follows the first stop bit; busy never drops; two frame_done pulses 10 ticks apart.
- Mid-frame: change p_data/par_en during DATA -> transmitted frame matches the latched values. Assert rst=0 during DATA -> tx_out=1 next edge, no frame_done.
- DATA_WIDTH=5, p_data=5'b10011, even parity -> bits 0,1,1,0,0,1,1(parity),1; frame = 8 ticks.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit engine.
// Holds the frame states, output-mux selects and parity-type encodings.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_t;

    localparam logic [1:0] MUX_START = 2'b00;
    localparam logic [1:0] MUX_DATA  = 2'b01;
    localparam logic [1:0] MUX_PAR   = 2'b10;
    localparam logic [1:0] MUX_STOP  = 2'b11;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // IDLE shares the stop-bit select because both drive the line high.
    function automatic logic [1:0] mux_sel(input state_t s);
        case (s)
            START:   return MUX_START;
            DATA:    return MUX_DATA;
            PARITY:  return MUX_PAR;
            default: return MUX_STOP;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Source-side handshake and frame configuration for the UART transmit engine.
// The master is the data source; the slave is the engine.
interface uart_tx_engine_if #(
    parameter int DATA_WIDTH = 8
) ();

    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_en;
    logic                  par_typ;
    logic                  stop2;
    logic                  busy;
    logic                  frame_done;

    modport master (
        output p_data, data_valid, par_en, par_typ, stop2,
        input  busy, frame_done
    );

    modport slave (
        input  p_data, data_valid, par_en, par_typ, stop2,
        output busy, frame_done
    );

endinterface

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit counter for the UART transmit engine.
// Loads a word, shifts it out LSB first and flags the last payload bit.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_shift,
    output logic                  o_bit,
    output logic                  o_done
);

    localparam int              CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;

    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the shift register is cleared on reset so no stale payload survives a restart.
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
            r_cnt   <= '0;
        end else if (i_shift) begin
            r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
            if (r_cnt != LAST) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_bit  = r_shift[0];
    assign o_done = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: frame FSM, parity generation and registered line mux.
// Frames advance one bit per baud_tick and may run back-to-back with no idle bit.
module uart_tx_engine
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            baud_tick,
    uart_tx_engine_if.slave tx_if,
    output logic            tx_out
);

    state_t r_state;
    logic   r_tx_out;
    logic   r_busy;
    logic   r_frame_done;
    logic   r_par_en;
    logic   r_stop2;
    logic   r_parity;

    logic   w_final_stop;
    logic   w_accept;
    logic   w_shift;
    logic   w_parity;
    logic   w_ser_bit;
    logic   w_ser_done;
    logic   w_mux_out;

    assign w_final_stop = baud_tick && ((r_state == STOP1 && !r_stop2) || r_state == STOP2);
    assign w_accept     = tx_if.data_valid && ((baud_tick && r_state == IDLE) || w_final_stop);
    assign w_shift      = baud_tick && (r_state == DATA);
    assign w_parity     = (^tx_if.p_data) ^ (tx_if.par_typ == PAR_ODD);

    uart_tx_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_serializer (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept),
        .i_data  (tx_if.p_data),
        .i_shift (w_shift),
        .o_bit   (w_ser_bit),
        .o_done  (w_ser_done)
    );

    // NOTE: the default assignment first guarantees no latch on any path.
    always_comb begin
        w_mux_out = 1'b1;
        case (mux_sel(r_state))
            MUX_START: w_mux_out = 1'b0;
            MUX_DATA:  w_mux_out = w_ser_bit;
            MUX_PAR:   w_mux_out = r_parity;
            MUX_STOP:  w_mux_out = 1'b1;
            default:   w_mux_out = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_tx_out     <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_par_en     <= 1'b0;
            r_stop2      <= 1'b0;
            r_parity     <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_tx_out     <= w_mux_out;

            if (w_accept) begin
                r_par_en <= tx_if.par_en;
                r_stop2  <= tx_if.stop2;
                r_parity <= w_parity;
            end

            // The last stop tick is both an end and, with data_valid, a new start.
            if (w_final_stop) begin
                r_frame_done <= 1'b1;
                if (tx_if.data_valid) begin
                    r_state <= START;
                end else begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            end else if (baud_tick) begin
                case (r_state)
                    IDLE: begin
                        if (tx_if.data_valid) begin
                            r_state <= START;
                            r_busy  <= 1'b1;
                        end
                    end
                    START:   r_state <= DATA;
                    DATA: begin
                        if (w_ser_done) begin
                            r_state <= r_par_en ? PARITY : STOP1;
                        end
                    end
                    PARITY:  r_state <= STOP1;
                    STOP1:   r_state <= STOP2;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign tx_out           = r_tx_out;
    assign tx_if.busy       = r_busy;
    assign tx_if.frame_done = r_frame_done;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: 8-bit and 5-bit instances sharing clock, reset and ticks.
// Expected line bits are queued when a frame is offered and popped as each bit period ends.
module tb_uart_tx_engine;

    logic clk = 1'b0;
    logic rst;
    logic baud_tick;
    logic tx_out8;
    logic tx_out5;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_cnt8 = 0;
    int   busy_cnt5 = 0;
    int   tick_div = 4;
    int   tick_cnt = 0;
    bit   tick_run = 1'b0;
    bit   sb_en = 1'b1;

    bit   exp8[$];
    bit   exp5[$];
    int   done8[$];
    int   done5[$];

    uart_tx_engine_if #(.DATA_WIDTH(8)) if8 ();
    uart_tx_engine_if #(.DATA_WIDTH(5)) if5 ();

    uart_tx_engine #(.DATA_WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .tx_if     (if8),
        .tx_out    (tx_out8)
    );

    uart_tx_engine #(.DATA_WIDTH(5)) dut5 (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .tx_if     (if5),
        .tx_out    (tx_out5)
    );

    always #5 clk = ~clk;

    // Tick generator: updated just after the rising edge so the monitor sees a settled value.
    initial begin
        baud_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tick_cnt >= tick_div - 1) tick_cnt = 0;
            else tick_cnt++;
            baud_tick = tick_run && (tick_cnt == 0);
        end
    end

    // Monitor and scoreboard: a bit is captured in the last cycle of each busy bit period.
    initial begin
        bit e8;
        bit e5;
        forever begin
            @(negedge clk);
            cyc++;
            if (if8.busy === 1'b1) busy_cnt8++;
            if (if5.busy === 1'b1) busy_cnt5++;
            if (if8.frame_done === 1'b1) done8.push_back(cyc);
            if (if5.frame_done === 1'b1) done5.push_back(cyc);
            if (sb_en && baud_tick === 1'b1 && if8.busy === 1'b1) begin
                checks++;
                if (exp8.size() == 0) begin
                    errors++;
                    $display("FAIL sb8_extra_bit: tx_out=%b at cycle %0d, expected no further bit", tx_out8, cyc);
                end else begin
                    e8 = exp8.pop_front();
                    if (tx_out8 !== e8) begin
                        errors++;
                        $display("FAIL sb8_bit: tx_out=%b, expected %b at cycle %0d", tx_out8, e8, cyc);
                    end
                end
            end
            if (sb_en && baud_tick === 1'b1 && if5.busy === 1'b1) begin
                checks++;
                if (exp5.size() == 0) begin
                    errors++;
                    $display("FAIL sb5_extra_bit: tx_out=%b at cycle %0d, expected no further bit", tx_out5, cyc);
                end else begin
                    e5 = exp5.pop_front();
                    if (tx_out5 !== e5) begin
                        errors++;
                        $display("FAIL sb5_bit: tx_out=%b, expected %b at cycle %0d", tx_out5, e5, cyc);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Reference frame: start, LSB-first payload, optional parity, one or two stop bits.
    task automatic push_exp(input int which, input logic [15:0] d, input int w,
                            input bit pe, input bit pt, input bit s2);
        bit q[$];
        bit par;
        par = pt;
        q.push_back(1'b0);
        for (int i = 0; i < w; i++) begin
            q.push_back(d[i]);
            par = par ^ d[i];
        end
        if (pe) q.push_back(par);
        q.push_back(1'b1);
        if (s2) q.push_back(1'b1);
        foreach (q[i]) begin
            if (which == 8) exp8.push_back(q[i]);
            else exp5.push_back(q[i]);
        end
    endtask

    task automatic wait_busy8(input string name);
        int n;
        n = 0;
        while (if8.busy !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (if8.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy_rise: busy=%b, expected 1 within 200 cycles", name, if8.busy);
        end
    endtask

    task automatic wait_done8(input int count, input string name);
        int n;
        n = 0;
        while (done8.size() < count && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done8.size() < count) begin
            errors++;
            $display("FAIL %s_done_wait: frame_done pulses=%0d, expected %0d within 400 cycles",
                     name, done8.size(), count);
        end
    endtask

    task automatic send8(input logic [7:0] d, input bit pe, input bit pt, input bit s2,
                         input string name);
        @(negedge clk);
        if8.p_data     = d;
        if8.par_en     = pe;
        if8.par_typ    = pt;
        if8.stop2      = s2;
        if8.data_valid = 1'b1;
        push_exp(8, 16'(d), 8, pe, pt, s2);
        wait_busy8(name);
        if8.data_valid = 1'b0;
    endtask

    task automatic finish8(input string name, input int ticks, input int ndone);
        wait_done8(ndone, name);
        repeat (2 * tick_div) @(negedge clk);
        checks++;
        if (busy_cnt8 !== ticks * tick_div) begin
            errors++;
            $display("FAIL %s_busy_len: busy cycles=%0d, expected %0d", name, busy_cnt8, ticks * tick_div);
        end
        checks++;
        if (done8.size() !== ndone) begin
            errors++;
            $display("FAIL %s_done_count: frame_done cycles=%0d, expected %0d", name, done8.size(), ndone);
        end
        checks++;
        if (exp8.size() !== 0) begin
            errors++;
            $display("FAIL %s_bits_missing: unsent bits=%0d, expected 0", name, exp8.size());
        end
    endtask

    task automatic test_reset();
        rst            = 1'b0;
        tick_div       = 4;
        tick_run       = 1'b1;
        if8.p_data     = 8'hA5;
        if8.data_valid = 1'b1;
        if5.data_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({tx_out8, if8.busy, if8.frame_done} !== 3'b100) begin
                errors++;
                $display("FAIL reset_hold: tx_out/busy/frame_done=%b, expected 100",
                         {tx_out8, if8.busy, if8.frame_done});
            end
        end
        checks++;
        if ({tx_out5, if5.busy, if5.frame_done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_hold5: tx_out/busy/frame_done=%b, expected 100",
                     {tx_out5, if5.busy, if5.frame_done});
        end
        if8.data_valid = 1'b0;
        if5.data_valid = 1'b0;
        rst            = 1'b1;
        busy_cnt8      = 0;
        repeat (12) @(negedge clk);
        checks++;
        if (busy_cnt8 !== 0 || tx_out8 !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_idle: busy cycles=%0d tx_out=%b, expected 0 and 1", busy_cnt8, tx_out8);
        end
        // data_valid without a tick must not start a frame.
        tick_run = 1'b0;
        @(negedge clk);
        if8.data_valid = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (busy_cnt8 !== 0) begin
            errors++;
            $display("FAIL valid_no_tick: busy cycles=%0d, expected 0", busy_cnt8);
        end
        if8.data_valid = 1'b0;
        tick_run       = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        tick_div  = 4;
        busy_cnt8 = 0;
        done8.delete();
        send8(8'hA5, 1'b0, 1'b0, 1'b0, "basic");
        finish8("basic", 10, 1);
    endtask

    task automatic test_parity();
        bit pt_tab[3]  = '{1'b0, 1'b1, 1'b0};
        bit s2_tab[3]  = '{1'b0, 1'b0, 1'b1};
        int div_tab[3] = '{4, 2, 4};
        for (int i = 0; i < 3; i++) begin
            tick_div  = div_tab[i];
            repeat (4) @(negedge clk);
            busy_cnt8 = 0;
            done8.delete();
            send8(8'h07, 1'b1, pt_tab[i], s2_tab[i], "parity");
            finish8("parity", s2_tab[i] ? 12 : 11, 1);
        end
    endtask

    task automatic test_back_to_back();
        tick_div  = 4;
        repeat (4) @(negedge clk);
        busy_cnt8 = 0;
        done8.delete();
        @(negedge clk);
        if8.p_data     = 8'h55;
        if8.par_en     = 1'b0;
        if8.par_typ    = 1'b0;
        if8.stop2      = 1'b0;
        if8.data_valid = 1'b1;
        push_exp(8, 16'h0055, 8, 1'b0, 1'b0, 1'b0);
        wait_busy8("b2b");
        if8.p_data = 8'hAA;
        push_exp(8, 16'h00AA, 8, 1'b0, 1'b0, 1'b0);
        wait_done8(1, "b2b_first");
        if8.data_valid = 1'b0;
        finish8("b2b", 20, 2);
        checks++;
        if (done8.size() == 2 && (done8[1] - done8[0]) !== 40) begin
            errors++;
            $display("FAIL b2b_spacing: frame_done gap=%0d cycles, expected 40", done8[1] - done8[0]);
        end else if (done8.size() != 2) begin
            errors++;
            $display("FAIL b2b_spacing: frame_done pulses=%0d, expected 2", done8.size());
        end
    endtask

    task automatic test_midframe();
        tick_div  = 4;
        repeat (4) @(negedge clk);
        busy_cnt8 = 0;
        done8.delete();
        send8(8'h3C, 1'b0, 1'b0, 1'b0, "midcfg");
        repeat (3 * tick_div) @(negedge clk);
        if8.p_data  = 8'hFF;
        if8.par_en  = 1'b1;
        if8.par_typ = 1'b1;
        if8.stop2   = 1'b1;
        finish8("midcfg", 10, 1);
        if8.par_en  = 1'b0;
        if8.par_typ = 1'b0;
        if8.stop2   = 1'b0;

        // Abandon a frame with reset while in the payload bits.
        sb_en = 1'b0;
        done8.delete();
        @(negedge clk);
        if8.p_data     = 8'h81;
        if8.data_valid = 1'b1;
        wait_busy8("midrst");
        if8.data_valid = 1'b0;
        repeat (3 * tick_div) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx_out8, if8.busy, if8.frame_done} !== 3'b100) begin
            errors++;
            $display("FAIL midrst_abort: tx_out/busy/frame_done=%b, expected 100",
                     {tx_out8, if8.busy, if8.frame_done});
        end
        rst = 1'b1;
        repeat (20 * tick_div) @(negedge clk);
        checks++;
        if (done8.size() !== 0 || if8.busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_done: frame_done pulses=%0d busy=%b, expected 0 and 0",
                     done8.size(), if8.busy);
        end
        sb_en = 1'b1;
    endtask

    task automatic test_width5();
        int n;
        tick_div  = 4;
        repeat (4) @(negedge clk);
        busy_cnt5 = 0;
        done5.delete();
        @(negedge clk);
        if5.p_data     = 5'b10011;
        if5.par_en     = 1'b1;
        if5.par_typ    = 1'b0;
        if5.stop2      = 1'b0;
        if5.data_valid = 1'b1;
        push_exp(5, 16'b10011, 5, 1'b1, 1'b0, 1'b0);
        n = 0;
        while (if5.busy !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if5.data_valid = 1'b0;
        n = 0;
        while (done5.size() < 1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (2 * tick_div) @(negedge clk);
        checks++;
        if (busy_cnt5 !== 8 * tick_div) begin
            errors++;
            $display("FAIL w5_busy_len: busy cycles=%0d, expected %0d", busy_cnt5, 8 * tick_div);
        end
        checks++;
        if (done5.size() !== 1) begin
            errors++;
            $display("FAIL w5_done_count: frame_done cycles=%0d, expected 1", done5.size());
        end
        checks++;
        if (exp5.size() !== 0) begin
            errors++;
            $display("FAIL w5_bits_missing: unsent bits=%0d, expected 0", exp5.size());
        end
    endtask

    initial begin
        if8.p_data     = '0;
        if8.data_valid = 1'b0;
        if8.par_en     = 1'b0;
        if8.par_typ    = 1'b0;
        if8.stop2      = 1'b0;
        if5.p_data     = '0;
        if5.data_valid = 1'b0;
        if5.par_en     = 1'b0;
        if5.par_typ    = 1'b0;
        if5.stop2      = 1'b0;
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_midframe();
        test_width5();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
